complex_matrix_add_arbiter: RTL and testbench
=============================================

// Module: complex_matrix_add_arbiter
// PURPOSE
//  Shares one complex_matrix_add array between NREQ requesters, each issuing add or sub jobs.
//  Round-robin grant; at most MAX_INFLIGHT jobs in flight; results returned in issue order to the issuer.
//  An in-order tag FIFO records the issuer of each job. Sits between client engines and the matrix adder.
// PARAMETERS
//  SIZE          16  complex lanes per job (matches adder array)
//  NREQ          4   number of requesters (>=2)
//  MAX_INFLIGHT  8   max accepted-but-unreturned jobs (power of 2, >=2)
// PORTS
//  clk_i           in   1                  clock
//  rst_ni          in   1                  async active-low reset
//  req_valid_i     in   NREQ               job request per requester
//  req_ready_o     out  NREQ               job accepted (one-hot or zero)
//  req_sub_i       in   NREQ               1=subtract, 0=add, per requester
//  req_operands_i  in   NREQ x SIZE*4x64   operands {b2,a2,b1,a1} per lane, per requester
//  rsp_valid_o     out  NREQ               result valid for requester (one-hot or zero)
//  rsp_ready_i     in   NREQ               requester takes result
//  rsp_result_o    out  SIZE*2x64          shared result bus
//  dp_in_valid_o   out  1                  to adder in_valid_i
//  dp_in_ready_i   in   1                  from adder in_ready_o
//  dp_operands_o   out  SIZE*4x64          to adder operands_i
//  dp_sub_o        out  1                  to adder sub
//  dp_out_valid_i  in   1                  from adder out_valid_o
//  dp_out_ready_o  out  1                  to adder out_ready_i
//  dp_result_i     in   SIZE*2x64          from adder result_o
//  dp_busy_i       in   1                  from adder busy_o
//  flush_i         in   1                  abort all in-flight jobs
//  dp_flush_o      out  1                  to adder flush_i (= flush_i, combinational)
//  busy_o          out  1                  tags outstanding or dp_busy_i
//  err_o           out  1                  sticky: result arrived with no outstanding tag
// BEHAVIOUR
//  Reset: all outputs 0; grant pointer=0; FIFO empty; err_o=0; FSM IDLE.
//  FSM IDLE: if any req_valid_i and count<MAX_INFLIGHT and !flush_i -> pick winner round-robin
//   starting at pointer, register index -> ISSUE. dp_in_valid_o=0 in IDLE.
//  ISSUE: dp_in_valid_o=1; dp_operands_o/dp_sub_o muxed from locked winner; grant and data stable until
//   dp_in_ready_i=1. On handshake: req_ready_o[winner]=1 same cycle, push winner tag, pointer=winner+1
//   mod NREQ, -> IDLE. Issue throughput 1 job per 2 cycles; requester must hold valid/data until ready.
//  Requester dropping req_valid_i in ISSUE: protocol violation, not checked; job still issued.
//  Credit: count = FIFO occupancy; push and pop same cycle leaves count unchanged; no issue when full.
//  Return path (combinational): head=FIFO head tag. rsp_valid_o[head]=dp_out_valid_i & !empty;
//   rsp_result_o=dp_result_i; dp_out_ready_o=rsp_ready_i[head] when non-empty. Pop on dp handshake.
//  dp_out_valid_i with FIFO empty: dp_out_ready_o=1 (drop), err_o set until reset.
//  flush_i: dp_flush_o=1 same cycle; FIFO cleared next edge; ISSUE->IDLE with no handshake
//   (req_ready_o=0); rsp_valid_o forced 0 while flush_i high; pointer kept.
//  busy_o = !empty | dp_busy_i | (state==ISSUE).
//  Reset mid-operation: immediate return to reset state; adder is reset by the same rst_ni.
// STRUCTURE
//  Package complex_matrix_pkg: localparam-derived types tag_t ([$clog2(NREQ)-1:0]),
//   cnt_t ([$clog2(MAX_INFLIGHT):0]), lane_ops_t (logic [3:0][63:0]), arb_state_e {IDLE,ISSUE}.
//  Sub-module complex_matrix_tag_fifo: sync FIFO of tag_t, depth MAX_INFLIGHT, push/pop/clear,
//   full/empty/count; pop-before-push semantics when full and popping (no issue permitted anyway).
// TESTING
//  1 Single req0 add, lane0 a1=1.0,b1=2.0,a2=3.0,b2=4.0 -> dp_sub_o=0, rsp_valid_o=0001, result {6.0,4.0}.
//  2 All 4 requesters valid continuously -> grant order 0,1,2,3,0; each gets result in that order.
//  3 Adder out_ready back-pressure: hold rsp_ready_i=0 -> 8 jobs issued, 9th waits in IDLE, busy_o=1.
//  4 req2 sub with dp_in_ready_i low 5 cycles -> dp_operands_o stable, req_ready_o[2] only at handshake.
//  5 flush_i with 3 in flight -> next cycle count=0, no rsp_valid_o, new job served normally after.
//  6 Inject dp_out_valid_i with empty FIFO -> dp_out_ready_o=1, err_o=1 and stays 1 until rst_ni.

Source files
------------

// File: rtl/complex_matrix_pkg.sv
// complex_matrix_pkg: shared sizes, types and arbitration helpers for the matrix-add arbiter
package complex_matrix_pkg;

    localparam int SIZE         = 16;
    localparam int NREQ         = 4;
    localparam int MAX_INFLIGHT = 8;

    typedef logic [$clog2(NREQ)-1:0]     tag_t;
    typedef logic [$clog2(MAX_INFLIGHT):0] cnt_t;
    typedef logic [3:0][63:0]            lane_ops_t;
    typedef lane_ops_t [SIZE-1:0]        ops_t;
    typedef logic [SIZE-1:0][1:0][63:0]  result_t;

    typedef enum logic {IDLE, ISSUE} arb_state_e;

    // First requesting index at or after the pointer, wrapping around
    function automatic tag_t rr_pick(input logic [NREQ-1:0] v, input tag_t p);
        tag_t w;
        tag_t i;
        w = p;
        for (int k = NREQ - 1; k >= 0; k--) begin
            i = tag_t'((int'(p) + k) % NREQ);
            if (v[i]) w = i;
        end
        return w;
    endfunction

    function automatic tag_t tag_inc(input tag_t t);
        return (t == tag_t'(NREQ - 1)) ? '0 : tag_t'(t + 1'b1);
    endfunction

endpackage

// File: rtl/complex_matrix_add_arbiter_if.sv
// complex_matrix_add_arbiter_if: requester-side and adder-side handshake bundle
interface complex_matrix_add_arbiter_if;
    import complex_matrix_pkg::*;

    logic [NREQ-1:0]  req_valid_i;
    logic [NREQ-1:0]  req_ready_o;
    logic [NREQ-1:0]  req_sub_i;
    ops_t [NREQ-1:0]  req_operands_i;
    logic [NREQ-1:0]  rsp_valid_o;
    logic [NREQ-1:0]  rsp_ready_i;
    result_t          rsp_result_o;
    logic             dp_in_valid_o;
    logic             dp_in_ready_i;
    ops_t             dp_operands_o;
    logic             dp_sub_o;
    logic             dp_out_valid_i;
    logic             dp_out_ready_o;
    result_t          dp_result_i;
    logic             dp_busy_i;
    logic             flush_i;
    logic             dp_flush_o;
    logic             busy_o;
    logic             err_o;

    modport slave (
        input  req_valid_i, req_sub_i, req_operands_i, rsp_ready_i,
               dp_in_ready_i, dp_out_valid_i, dp_result_i, dp_busy_i, flush_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o, dp_operands_o,
               dp_sub_o, dp_out_ready_o, dp_flush_o, busy_o, err_o
    );

    modport master (
        output req_valid_i, req_sub_i, req_operands_i, rsp_ready_i,
               dp_in_ready_i, dp_out_valid_i, dp_result_i, dp_busy_i, flush_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, dp_in_valid_o, dp_operands_o,
               dp_sub_o, dp_out_ready_o, dp_flush_o, busy_o, err_o
    );

endinterface

// File: rtl/complex_matrix_tag_fifo.sv
// complex_matrix_tag_fifo: in-order record of which requester issued each outstanding job
module complex_matrix_tag_fifo
    import complex_matrix_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  tag_t din,
    output tag_t head,
    output logic empty,
    output cnt_t count
);

    localparam int AW = $clog2(MAX_INFLIGHT);

    tag_t           mem [MAX_INFLIGHT];
    logic [AW-1:0]  rd, wr;
    logic           do_pop, do_push;

    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != cnt_t'(MAX_INFLIGHT) || do_pop);
    assign head    = mem[rd];

    // Tag storage; contents are don't-care until pointed at, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr] <= din;
    end

    // Pointers and occupancy; clear wins over any concurrent push or pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (clear) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
        end
    end

endmodule

// File: rtl/complex_matrix_add_arbiter.sv
// complex_matrix_add_arbiter: round-robin sharing of one matrix adder with in-order result routing
module complex_matrix_add_arbiter
    import complex_matrix_pkg::*;
(
    input logic                           clk_i,
    input logic                           rst_ni,
    complex_matrix_add_arbiter_if.slave   bus
);

    arb_state_e state, state_next;
    tag_t       win, win_next, ptr, head;
    cnt_t       count;
    logic       empty, full, issue, hs, pop, err;

    assign full  = count == cnt_t'(MAX_INFLIGHT);
    assign issue = state == ISSUE;
    assign hs    = issue && bus.dp_in_ready_i && !bus.flush_i;
    assign pop   = bus.dp_out_valid_i && bus.dp_out_ready_o && !empty;

    complex_matrix_tag_fifo u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (hs),
        .pop   (pop),
        .clear (bus.flush_i),
        .din   (win),
        .head  (head),
        .empty (empty),
        .count (count)
    );

    // Lock a winner while idle if a credit is free; release on handshake or flush
    always_comb begin
        state_next = state;
        win_next   = win;
        if (!issue) begin
            if (|bus.req_valid_i && !full && !bus.flush_i) begin
                state_next = ISSUE;
                win_next   = rr_pick(bus.req_valid_i, ptr);
            end
        end else if (hs || bus.flush_i) begin
            state_next = IDLE;
        end
    end

    // State, locked winner, and pointer advancing past each accepted winner
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            win   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            win   <= win_next;
            if (hs) ptr <= tag_inc(win);
        end
    end

    // A result with nothing outstanding is remembered until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err <= 1'b0;
        else if (bus.dp_out_valid_i && empty) err <= 1'b1;
    end

    assign bus.req_ready_o    = hs ? (NREQ'(1) << win) : '0;
    assign bus.dp_in_valid_o  = issue;
    assign bus.dp_operands_o  = issue ? bus.req_operands_i[win] : '0;
    assign bus.dp_sub_o       = issue && bus.req_sub_i[win];
    assign bus.rsp_valid_o    = (bus.dp_out_valid_i && !empty && !bus.flush_i) ? (NREQ'(1) << head) : '0;
    assign bus.rsp_result_o   = bus.dp_result_i;
    assign bus.dp_out_ready_o = empty ? bus.dp_out_valid_i : bus.rsp_ready_i[head];
    assign bus.dp_flush_o     = bus.flush_i;
    assign bus.busy_o         = !empty || bus.dp_busy_i || issue;
    assign bus.err_o          = err;

endmodule

// File: tb/tb_complex_matrix_add_arbiter.sv
// tb_complex_matrix_add_arbiter: randomized requesters and adder model against a queue-based reference
module tb_complex_matrix_add_arbiter;
    import complex_matrix_pkg::*;

    typedef struct {
        tag_t    tag;
        result_t res;
    } job_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;
    ops_t            m_ops [NREQ];
    logic [NREQ-1:0] m_valid = '0;
    logic [NREQ-1:0] m_sub = '0;
    int              left [NREQ];
    job_t            aq [$];
    int              ptr_m = 0;
    logic            err_m = 1'b0;
    logic            out_en = 1'b0;
    logic            inject = 1'b0;
    int              issued = 0;
    int              issue_log [$];
    int              ret_log [$];
    logic [NREQ-1:0] cap_valid = '0;
    result_t         cap_res = '0;
    int              base;
    int              n;
    int              exp2 [5] = '{0, 1, 2, 3, 0};

    complex_matrix_add_arbiter_if bus ();

    complex_matrix_add_arbiter dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fold(input logic [4095:0] v);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 64; i++) f ^= v[i*64 +: 64];
        return f;
    endfunction

    function automatic int rr(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return p;
    endfunction

    function automatic result_t calc(input ops_t o, input logic s);
        result_t r;
        real a1, b1, a2, b2;
        for (int l = 0; l < SIZE; l++) begin
            a1 = $bitstoreal(o[l][0]);
            b1 = $bitstoreal(o[l][1]);
            a2 = $bitstoreal(o[l][2]);
            b2 = $bitstoreal(o[l][3]);
            r[l][0] = $realtobits(s ? a1 - a2 : a1 + a2);
            r[l][1] = $realtobits(s ? b1 - b2 : b1 + b2);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [4095:0] obs, input logic [4095:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (xor-folded)", tag, fold(obs), fold(exp));
        end
    endtask

    task automatic new_job(input int i, input logic s);
        for (int l = 0; l < SIZE; l++)
            for (int k = 0; k < 4; k++)
                m_ops[i][l][k] = $realtobits(real'($urandom_range(200)) - 100.0);
        m_sub[i]   = s;
        m_valid[i] = 1'b1;
    endtask

    task automatic drive();
        bus.req_valid_i = m_valid;
        bus.req_sub_i   = m_sub;
        for (int i = 0; i < NREQ; i++) bus.req_operands_i[i] = m_ops[i];
        bus.dp_out_valid_i = inject || (out_en && aq.size() > 0);
        bus.dp_result_i    = inject ? {(SIZE*2){64'hdead_beef_0bad_f00d}} : (aq.size() > 0 ? aq[0].res : '0);
    endtask

    task automatic tick();
        logic in_hs, out_hs;
        int   w;
        tag_t hd;
        drive();
        @(negedge clk);
        w      = rr(m_valid, ptr_m);
        hd     = aq.size() > 0 ? aq[0].tag : '0;
        in_hs  = bus.dp_in_valid_o && bus.dp_in_ready_i && !bus.flush_i;
        out_hs = bus.dp_out_valid_i && bus.dp_out_ready_o;
        chk("req_ready", bus.req_ready_o, in_hs ? (1 << w) : 0);
        if (bus.dp_in_valid_o) begin
            chk("dp_operands", bus.dp_operands_o, m_ops[w]);
            chk("dp_sub", bus.dp_sub_o, m_sub[w]);
        end
        if (aq.size() == MAX_INFLIGHT) chk("credit_stall", bus.dp_in_valid_o, 0);
        chk("rsp_valid", bus.rsp_valid_o, (!bus.flush_i && bus.dp_out_valid_i && aq.size() > 0) ? (1 << hd) : 0);
        if (bus.dp_out_valid_i) chk("dp_out_ready", bus.dp_out_ready_o, aq.size() == 0 ? 1'b1 : bus.rsp_ready_i[hd]);
        chk("rsp_result", bus.rsp_result_o, bus.dp_result_i);
        chk("busy", bus.busy_o, aq.size() > 0 || bus.dp_busy_i || bus.dp_in_valid_o);
        chk("err", bus.err_o, err_m);
        chk("dp_flush", bus.dp_flush_o, bus.flush_i);
        if (out_hs && bus.rsp_valid_o != 0) begin
            cap_valid = bus.rsp_valid_o;
            cap_res   = bus.rsp_result_o;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (out_hs && aq.size() == 0) err_m = 1'b1;
            if (bus.flush_i) aq.delete();
            else begin
                if (out_hs && aq.size() > 0) begin
                    ret_log.push_back(int'(aq[0].tag));
                    aq.pop_front();
                end
                if (in_hs) begin
                    aq.push_back('{tag: tag_t'(w), res: calc(m_ops[w], m_sub[w])});
                    issue_log.push_back(w);
                    issued++;
                    ptr_m = (w + 1) % NREQ;
                    left[w]--;
                    if (left[w] > 0) new_job(w, 1'($urandom_range(1)));
                    else m_valid[w] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((aq.size() > 0 || m_valid != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", k < budget, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        aq.delete();
        m_valid = '0;
        err_m   = 1'b0;
        ptr_m   = 0;
        inject  = 1'b0;
        bus.flush_i = 1'b0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        drive();
        #1;
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_dp_in_valid", bus.dp_in_valid_o, 0);
        chk("rst_dp_out_ready", bus.dp_out_ready_o, 0);
        chk("rst_dp_sub", bus.dp_sub_o, 0);
        chk("rst_dp_operands", bus.dp_operands_o, 0);
        chk("rst_rsp_result", bus.rsp_result_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_dp_flush", bus.dp_flush_o, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) m_ops[i] = '0;
        bus.rsp_ready_i   = '1;
        bus.dp_in_ready_i = 1'b1;
        bus.dp_busy_i     = 1'b0;
        bus.flush_i       = 1'b0;
        do_reset();

        // single add from requester 0 with known lane-0 values
        out_en = 1'b1;
        left[0] = 1;
        new_job(0, 1'b0);
        m_ops[0][0] = {$realtobits(4.0), $realtobits(3.0), $realtobits(2.0), $realtobits(1.0)};
        drain(50);
        chk("t1_rsp_valid", cap_valid, 4'b0001);
        chk("t1_lane0", cap_res[0], {$realtobits(6.0), $realtobits(4.0)});

        // all four requesters continuously valid from a fresh pointer
        do_reset();
        issue_log.delete();
        ret_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = (i == 0) ? 2 : 1;
            new_job(i, 1'($urandom_range(1)));
        end
        drain(100);
        chk("t2_grants_n", issue_log.size(), 5);
        chk("t2_returns_n", ret_log.size(), 5);
        for (int i = 0; i < 5 && i < issue_log.size() && i < ret_log.size(); i++) begin
            chk("t2_grant_order", issue_log[i], exp2[i]);
            chk("t2_return_order", ret_log[i], exp2[i]);
        end

        // result back-pressure fills every credit
        base = issued;
        bus.rsp_ready_i = '0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 3;
            new_job(i, 1'($urandom_range(1)));
        end
        repeat (40) tick();
        chk("t3_issued", issued - base, MAX_INFLIGHT);
        chk("t3_in_valid", bus.dp_in_valid_o, 0);
        chk("t3_busy", bus.busy_o, 1);
        bus.rsp_ready_i = 4'($urandom_range(1, 15));
        repeat (20) tick();
        bus.rsp_ready_i = '1;
        drain(300);
        chk("t3_all_issued", issued - base, 12);

        // subtract from requester 2 held off by the adder for five cycles
        bus.dp_in_ready_i = 1'b0;
        left[2] = 1;
        new_job(2, 1'b1);
        tick();
        repeat (5) tick();
        chk("t4_hold_valid", bus.dp_in_valid_o, 1);
        chk("t4_no_ready", bus.req_ready_o, 0);
        chk("t4_sub", bus.dp_sub_o, 1);
        bus.dp_in_ready_i = 1'b1;
        drain(50);
        chk("t4_issuer", issue_log.size() > 0 ? issue_log[issue_log.size() - 1] : -1, 2);

        // flush with three jobs outstanding
        out_en = 1'b0;
        base = issued;
        for (int i = 0; i < 3; i++) begin
            left[i] = 1;
            new_job(i, 1'($urandom_range(1)));
        end
        n = 0;
        while (issued - base < 3 && n < 30) begin
            tick();
            n++;
        end
        chk("t5_issue_timeout", n < 30, 1);
        out_en = 1'b1;
        bus.flush_i = 1'b1;
        drive();
        #1;
        chk("t5_rsp_valid_flush", bus.rsp_valid_o, 0);
        chk("t5_dp_flush", bus.dp_flush_o, 1);
        tick();
        bus.flush_i = 1'b0;
        drive();
        #1;
        chk("t5_busy_cleared", bus.busy_o, 0);
        chk("t5_rsp_valid_after", bus.rsp_valid_o, 0);
        ret_log.delete();
        left[1] = 1;
        new_job(1, 1'b0);
        drain(50);
        chk("t5_new_job", ret_log.size() == 1 && ret_log[0] == 1, 1);

        // stray result with nothing outstanding
        inject = 1'b1;
        tick();
        inject = 1'b0;
        bus.dp_busy_i = 1'b1;
        tick();
        bus.dp_busy_i = 1'b0;
        repeat (3) tick();
        chk("t6_err_sticky", bus.err_o, 1);

        // reset in the middle of an issue
        bus.dp_in_ready_i = 1'b0;
        left[3] = 1;
        new_job(3, 1'b0);
        tick();
        tick();
        chk("t7_in_issue", bus.dp_in_valid_o, 1);
        do_reset();
        bus.dp_in_ready_i = 1'b1;
        ret_log.delete();
        left[2] = 1;
        new_job(2, 1'b1);
        drain(50);
        chk("t7_after_reset", ret_log.size() == 1 && ret_log[0] == 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
